cp0_mmu_regs: RTL and testbench

CP0_MMU_REGS -- requirements
Module: cp0_mmu_regs

---
 rtl/cp0_mmu_regs_pkg.sv | 41 ++++
 rtl/cp0_mmu_regs_random.sv | 43 ++++
 rtl/cp0_mmu_regs.sv | 200 ++++++++++++++++++++
 tb/tb_cp0_mmu_regs.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cp0_mmu_regs_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, vectors and the TLB entry layout.
package cp0_mmu_regs_pkg;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_CONTEXT  = 5'd4;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] VEC_REFILL  = 32'hBFC0_0200;
  localparam logic [31:0] VEC_GENERAL = 32'hBFC0_0380;

  // Per-page field is {PFN[19:0], C[2:0], D, V}.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [24:0] lo0;
    logic [24:0] lo1;
  } tlb_entry_t;

endpackage

// File: rtl/cp0_mmu_regs_random.sv
// Random/Wired pair: Random counts down from TLBNUM-1 to Wired, then wraps back to the top.
module cp0_random #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wired_wen_i,
  input  logic [IW-1:0] wired_wdata_i,
  output logic [IW-1:0] random_o,
  output logic [IW-1:0] wired_o
);

  localparam logic [IW-1:0] TOP = IW'(TLBNUM - 1);

  logic [IW-1:0] random_q, random_d;
  logic [IW-1:0] wired_q, wired_d;

  always_comb begin
    random_d = random_q - IW'(1);
    wired_d  = wired_q;
    if (wired_wen_i) begin
      wired_d  = wired_wdata_i;
      random_d = TOP;
    end else if (random_q == wired_q || wired_q >= TOP) begin
      random_d = TOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= TOP;
      wired_q  <= '0;
    end else begin
      random_q <= random_d;
      wired_q  <= wired_d;
    end
  end

  assign random_o = random_q;
  assign wired_o  = wired_q;

endmodule

// File: rtl/cp0_mmu_regs.sv
// CP0 register file with the MMU registers: exception state, timer, interrupts and TLB staging.
module cp0_mmu_regs
  import cp0_mmu_regs_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int HW_INT = 6,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cp0_addr,
  input  logic              cp0_wen,
  input  logic [31:0]       cp0_wdata,
  output logic [31:0]       cp0_rdata,
  input  logic              exc_valid,
  input  logic [4:0]        exc_code,
  input  logic              exc_bd,
  input  logic              exc_refill,
  input  logic [31:0]       exc_pc,
  input  logic [31:0]       exc_badvaddr,
  input  logic              exc_badv_wen,
  input  logic              eret,
  input  logic [HW_INT-1:0] hw_int,
  output logic              int_pending,
  output logic [31:0]       epc,
  output logic [31:0]       exc_vector,
  input  logic              tlbp_wen,
  input  logic              tlbp_hit,
  input  logic [IW-1:0]     tlbp_idx,
  input  logic              tlbr_wen,
  input  logic [77:0]       tlbr_entry,
  input  logic              tlbwr,
  output logic [IW-1:0]     tlb_widx,
  output logic [77:0]       tlb_wentry,
  output logic [31:0]       entryhi
);

  logic [4:0] rsel;
  logic       mtc0;
  assign rsel = cp0_addr[7:3];
  // Committed exceptions and ERET take the whole cycle; a same-cycle MTC0 is dropped.
  assign mtc0 = cp0_wen && (cp0_addr[2:0] == 3'd0) && !exc_valid && !eret;

  tlb_entry_t tr;
  assign tr = tlb_entry_t'(tlbr_entry);

  logic              index_p_q;
  logic [IW-1:0]     index_q;
  logic [25:0]       lo0_q, lo1_q;
  logic [8:0]        ptebase_q;
  logic [18:0]       badvpn2_q;
  logic [31:0]       badvaddr_q, count_q, compare_q, epc_q;
  logic              phase_q;
  logic [18:0]       vpn2_q;
  logic [7:0]        asid_q, im_q;
  logic              exl_q, ie_q, bd_q, ti_q;
  logic [HW_INT-1:0] ip_hw_q;
  logic [1:0]        ip_sw_q;
  logic [4:0]        exccode_q;
  logic [IW-1:0]     random, wired;

  cp0_random #(.TLBNUM(TLBNUM)) u_random (
    .clk           (clk),
    .rst           (rst),
    .wired_wen_i   (mtc0 && rsel == CP0_WIRED),
    .wired_wdata_i (cp0_wdata[IW-1:0]),
    .random_o      (random),
    .wired_o       (wired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      index_p_q  <= 1'b0;
      index_q    <= '0;
      lo0_q      <= '0;
      lo1_q      <= '0;
      ptebase_q  <= '0;
      badvpn2_q  <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      phase_q    <= 1'b0;
      compare_q  <= '0;
      vpn2_q     <= '0;
      asid_q     <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      epc_q      <= '0;
    end else begin
      if (tlbp_wen) begin
        index_p_q <= ~tlbp_hit;
        index_q   <= tlbp_hit ? tlbp_idx : '0;
      end else if (mtc0 && rsel == CP0_INDEX) begin
        index_q <= cp0_wdata[IW-1:0];
      end

      if (tlbr_wen) begin
        lo0_q <= {tr.lo0, tr.g};
        lo1_q <= {tr.lo1, tr.g};
      end else begin
        if (mtc0 && rsel == CP0_ENTRYLO0) lo0_q <= cp0_wdata[25:0];
        if (mtc0 && rsel == CP0_ENTRYLO1) lo1_q <= cp0_wdata[25:0];
      end

      if (exc_valid && exc_badv_wen) begin
        vpn2_q <= exc_badvaddr[31:13];
      end else if (tlbr_wen) begin
        vpn2_q <= tr.vpn2;
        asid_q <= tr.asid;
      end else if (mtc0 && rsel == CP0_ENTRYHI) begin
        vpn2_q <= cp0_wdata[31:13];
        asid_q <= cp0_wdata[7:0];
      end

      if (mtc0 && rsel == CP0_CONTEXT) ptebase_q <= cp0_wdata[31:23];
      if (exc_badv_wen) begin
        badvpn2_q  <= exc_badvaddr[31:13];
        badvaddr_q <= exc_badvaddr;
      end

      // Count ticks on every second cycle; a write restarts the half-rate phase.
      if (mtc0 && rsel == CP0_COUNT) begin
        count_q <= cp0_wdata;
        phase_q <= 1'b0;
      end else begin
        phase_q <= ~phase_q;
        if (phase_q) count_q <= count_q + 32'd1;
      end

      if (mtc0 && rsel == CP0_COMPARE) begin
        compare_q <= cp0_wdata;
        ti_q      <= 1'b0;
      end else if (count_q == compare_q) begin
        ti_q <= 1'b1;
      end

      if (exc_valid) begin
        exl_q <= 1'b1;
      end else if (eret) begin
        exl_q <= 1'b0;
      end else if (mtc0 && rsel == CP0_STATUS) begin
        im_q  <= cp0_wdata[15:8];
        exl_q <= cp0_wdata[1];
        ie_q  <= cp0_wdata[0];
      end

      ip_hw_q <= hw_int;
      if (exc_valid) begin
        exccode_q <= exc_code;
        if (!exl_q) begin
          bd_q  <= exc_bd;
          epc_q <= exc_bd ? exc_pc - 32'd4 : exc_pc;
        end
      end else begin
        if (mtc0 && rsel == CP0_CAUSE) ip_sw_q <= cp0_wdata[9:8];
        if (mtc0 && rsel == CP0_EPC)   epc_q   <= cp0_wdata;
      end
    end
  end

  logic [5:0] ip_hw6;
  logic [7:0] ip;
  assign ip_hw6 = 6'(ip_hw_q);
  assign ip     = {ip_hw6[5] | ti_q, ip_hw6[4:0], ip_sw_q};

  assign int_pending = ie_q && !exl_q && |(im_q & ip);
  assign exc_vector  = (!exl_q && exc_refill) ? VEC_REFILL : VEC_GENERAL;
  assign epc         = epc_q;
  assign entryhi     = {vpn2_q, 5'b0, asid_q};
  assign tlb_widx    = tlbwr ? random : index_q;
  assign tlb_wentry  = {vpn2_q, asid_q, lo0_q[0] & lo1_q[0], lo0_q[25:1], lo1_q[25:1]};

  always_comb begin
    cp0_rdata = '0;
    if (cp0_addr[2:0] == 3'd0) begin
      case (rsel)
        CP0_INDEX:    cp0_rdata = {index_p_q, {(31-IW){1'b0}}, index_q};
        CP0_RANDOM:   cp0_rdata = {{(32-IW){1'b0}}, random};
        CP0_ENTRYLO0: cp0_rdata = {6'b0, lo0_q};
        CP0_ENTRYLO1: cp0_rdata = {6'b0, lo1_q};
        CP0_CONTEXT:  cp0_rdata = {ptebase_q, badvpn2_q, 4'b0};
        CP0_WIRED:    cp0_rdata = {{(32-IW){1'b0}}, wired};
        CP0_BADVADDR: cp0_rdata = badvaddr_q;
        CP0_COUNT:    cp0_rdata = count_q;
        CP0_ENTRYHI:  cp0_rdata = {vpn2_q, 5'b0, asid_q};
        CP0_COMPARE:  cp0_rdata = compare_q;
        CP0_STATUS:   cp0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
        CP0_CAUSE:    cp0_rdata = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};
        CP0_EPC:      cp0_rdata = epc_q;
        default:      cp0_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_mmu_regs.sv
// Directed bench for cp0_mmu_regs: reset, Random/Wired, TLB staging, exceptions, timer, interrupts.
module tb_cp0_mmu_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cp0_addr;
  logic        cp0_wen;
  logic [31:0] cp0_wdata, cp0_rdata;
  logic        exc_valid, exc_bd, exc_refill, exc_badv_wen, eret;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badvaddr;
  logic [5:0]  hw_int;
  logic        int_pending;
  logic [31:0] epc, exc_vector, entryhi;
  logic        tlbp_wen, tlbp_hit, tlbr_wen, tlbwr;
  logic [3:0]  tlbp_idx, tlb_widx;
  logic [77:0] tlbr_entry, tlb_wentry;

  int n_chk = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  cp0_mmu_regs #(.TLBNUM(16), .HW_INT(6)) dut (
    .clk(clk), .rst(rst), .cp0_addr(cp0_addr), .cp0_wen(cp0_wen), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .exc_valid(exc_valid), .exc_code(exc_code), .exc_bd(exc_bd),
    .exc_refill(exc_refill), .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr),
    .exc_badv_wen(exc_badv_wen), .eret(eret), .hw_int(hw_int), .int_pending(int_pending),
    .epc(epc), .exc_vector(exc_vector), .tlbp_wen(tlbp_wen), .tlbp_hit(tlbp_hit),
    .tlbp_idx(tlbp_idx), .tlbr_wen(tlbr_wen), .tlbr_entry(tlbr_entry), .tlbwr(tlbwr),
    .tlb_widx(tlb_widx), .tlb_wentry(tlb_wentry), .entryhi(entryhi)
  );

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    cp0_addr = {r, 3'b0}; cp0_wdata = d; cp0_wen = 1'b1;
    tick();
    cp0_wen = 1'b0;
  endtask

  task automatic chkreg(input string tag, input logic [4:0] r, input logic [31:0] msk,
                        input logic [31:0] exp);
    cp0_addr = {r, 3'b0};
    #1;
    chk(tag, 80'(cp0_rdata & msk), 80'(exp));
  endtask

  logic [18:0] t_vpn2;
  logic [7:0]  t_asid;
  logic [24:0] t_lo0, t_lo1;

  initial begin
    rst = 1'b1; cp0_addr = '0; cp0_wen = 1'b0; cp0_wdata = '0;
    exc_valid = 1'b0; exc_code = '0; exc_bd = 1'b0; exc_refill = 1'b0; exc_pc = '0;
    exc_badvaddr = '0; exc_badv_wen = 1'b0; eret = 1'b0; hw_int = '0;
    tlbp_wen = 1'b0; tlbp_hit = 1'b0; tlbp_idx = '0; tlbr_wen = 1'b0; tlbr_entry = '0;
    tlbwr = 1'b0;

    // Reset held while an exception commits: reset must win.
    tick(2);
    exc_valid = 1'b1; exc_code = 5'd2;
    tick(2);
    exc_valid = 1'b0;
    chkreg("rst_status", 5'd12, 32'hFFFFFFFF, 32'h0040_0000);
    chkreg("rst_cause",  5'd13, 32'hFFFFFFFF, 32'h0);
    chkreg("rst_index",  5'd0,  32'hFFFFFFFF, 32'h0);
    chkreg("rst_random", 5'd1,  32'hFFFFFFFF, 32'd15);
    chkreg("rst_epc",    5'd14, 32'hFFFFFFFF, 32'h0);
    chkreg("rst_count",  5'd9,  32'hFFFFFFFF, 32'h0);
    chkreg("rst_ehi",    5'd10, 32'hFFFFFFFF, 32'h0);
    chk("rst_intp", 80'(int_pending), 80'(0));
    chk("rst_vec",  80'(exc_vector), 80'(32'hBFC0_0380));

    // Free-running Random with Wired=0.
    rst = 1'b0;
    tick(20);
    chkreg("rand_20", 5'd1, 32'hFFFFFFFF, 32'd11);

    mtc0(5'd6, 32'hFFFF_FFFA);
    chkreg("wired_rd",    5'd6, 32'hFFFFFFFF, 32'd10);
    chkreg("rand_wwr",    5'd1, 32'hFFFFFFFF, 32'd15);
    tick(5);
    chkreg("rand_at_w",   5'd1, 32'hFFFFFFFF, 32'd10);
    tick();
    chkreg("rand_wrap_w", 5'd1, 32'hFFFFFFFF, 32'd15);
    mtc0(5'd6, 32'd15);
    tick(3);
    chkreg("rand_hold15", 5'd1, 32'hFFFFFFFF, 32'd15);

    // TLBP miss / hit and TLBWR index selection.
    mtc0(5'd6, 32'd0);
    tick(8);
    tlbp_wen = 1'b1; tlbp_hit = 1'b0; tlbp_idx = 4'd3; tlbwr = 1'b1;
    #1;
    chk("widx_rand", 80'(tlb_widx), 80'(7));
    tick();
    tlbp_wen = 1'b0; tlbwr = 1'b0;
    chkreg("idx_miss", 5'd0, 32'hFFFFFFFF, 32'h8000_0000);
    chk("widx_idx0", 80'(tlb_widx), 80'(0));
    tlbp_wen = 1'b1; tlbp_hit = 1'b1; tlbp_idx = 4'd5;
    tick();
    tlbp_wen = 1'b0;
    chkreg("idx_hit", 5'd0, 32'hFFFFFFFF, 32'd5);
    chk("widx_idx5", 80'(tlb_widx), 80'(5));

    // TLBR beats a same-cycle MTC0 to EntryLo0.
    t_vpn2 = 19'h12345; t_asid = 8'h5A;
    t_lo0 = {20'hABCDE, 3'd3, 1'b1, 1'b1};
    t_lo1 = {20'h13579, 3'd2, 1'b0, 1'b1};
    tlbr_entry = {t_vpn2, t_asid, 1'b1, t_lo0, t_lo1};
    tlbr_wen = 1'b1;
    mtc0(5'd2, 32'h0123_4567);
    tlbr_wen = 1'b0;
    chkreg("tlbr_lo0", 5'd2, 32'hFFFFFFFF, {6'b0, t_lo0, 1'b1});
    chkreg("tlbr_lo1", 5'd3, 32'hFFFFFFFF, {6'b0, t_lo1, 1'b1});
    chkreg("tlbr_ehi", 5'd10, 32'hFFFFFFFF, {t_vpn2, 5'b0, t_asid});
    chk("tlbr_went", 80'(tlb_wentry), 80'({t_vpn2, t_asid, 1'b1, t_lo0, t_lo1}));
    mtc0(5'd3, 32'hFFFF_FFFE);
    chkreg("lo1_rsvd", 5'd3, 32'hFFFFFFFF, 32'h03FF_FFFE);
    chk("went_g", 80'(tlb_wentry[50]), 80'(0));

    // Refill exception in a delay slot.
    mtc0(5'd10, 32'h0000_00A5);
    mtc0(5'd4, 32'hFFFF_FFFF);
    chkreg("ctx_pte", 5'd4, 32'hFFFFFFFF, 32'hFF80_0000);
    exc_valid = 1'b1; exc_refill = 1'b1; exc_bd = 1'b1; exc_code = 5'd2;
    exc_pc = 32'h8000_1004; exc_badvaddr = 32'h0040_2ABC; exc_badv_wen = 1'b1;
    #1;
    chk("vec_refill", 80'(exc_vector), 80'(32'hBFC0_0200));
    tick();
    exc_valid = 1'b0; exc_badv_wen = 1'b0;
    chk("epc_bd", 80'(epc), 80'(32'h8000_1000));
    chkreg("cause_exc", 5'd13, 32'h8000_007C, 32'h8000_0008);
    chkreg("ehi_vpn2",  5'd10, 32'hFFFFFFFF, 32'h0040_20A5);
    chkreg("ctx_bvpn",  5'd4,  32'hFFFFFFFF, 32'hFF80_2010);
    chkreg("badvaddr",  5'd8,  32'hFFFFFFFF, 32'h0040_2ABC);
    chkreg("st_exl",    5'd12, 32'hFFFFFFFF, 32'h0040_0002);
    exc_valid = 1'b1; exc_bd = 1'b0; exc_pc = 32'h8000_2000;
    #1;
    chk("vec_nested", 80'(exc_vector), 80'(32'hBFC0_0380));
    tick();
    exc_valid = 1'b0; exc_refill = 1'b0;
    chk("epc_hold", 80'(epc), 80'(32'h8000_1000));
    chkreg("bd_hold", 5'd13, 32'h8000_0000, 32'h8000_0000);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chkreg("st_eret", 5'd12, 32'hFFFFFFFF, 32'h0040_0000);

    // Timer interrupt: Count reaches Compare=5 ten cycles after the Count write.
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    tick(8);
    chk("ti_early", 80'(int_pending), 80'(0));
    tick(2);
    chk("ti_pend", 80'(int_pending), 80'(1));
    chkreg("count5", 5'd9, 32'hFFFFFFFF, 32'd5);
    chkreg("cause_ti", 5'd13, 32'h4000_8000, 32'h4000_8000);
    mtc0(5'd11, 32'd100);
    chk("ti_clr", 80'(int_pending), 80'(0));

    // Exception, ERET and MTC0 Status in one cycle.
    exc_valid = 1'b1; exc_code = 5'd8; eret = 1'b1;
    mtc0(5'd12, 32'h0000_FF00);
    exc_valid = 1'b0; eret = 1'b0;
    chkreg("st_prio", 5'd12, 32'hFFFFFFFF, 32'h0040_8003);
    chkreg("code_sys", 5'd13, 32'h0000_007C, 32'h0000_0020);

    // Hardware and software interrupt lines.
    eret = 1'b1;
    tick();
    eret = 1'b0;
    hw_int = 6'b000001;
    mtc0(5'd13, 32'h0000_0300);
    chkreg("ip_bits", 5'd13, 32'h0000_7F00, 32'h0000_0700);
    mtc0(5'd12, 32'h0000_0401);
    chk("hw_pend", 80'(int_pending), 80'(1));
    hw_int = '0;
    mtc0(5'd13, 32'h0);
    tick();
    chk("hw_clr", 80'(int_pending), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
